crc_arbiter: RTL
================

# crc_arbiter

Round-robin arbiter and sequencer that shares a single `crc` engine among `NUM_REQ` requesters. It takes one 32-bit word per job and drives the engine's reset, enable and data lines through the same sequence for every job. It captures the 16-bit result on `crc_done` and returns it to the requester that owns the job. A cycle-count timeout ends any job whose engine never reports done.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..16.
- `TIMEOUT`, 64: maximum RUN cycles per job, at least 2.
- `IDW`: derived, max(1, $clog2(NUM_REQ)).

- `clk`  in  1: single clock; everything is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  NUM_REQ: per-requester job request.
- `req_data`  in  32*NUM_REQ: requester i's word on bits [32i+31:32i]; must be stable while `req[i]` is high.
- `gnt`  out  NUM_REQ: one-hot owner of the current job; zero when idle.
- `rsp_valid`  out  1: one-cycle pulse when a result is ready.
- `rsp_id`  out  IDW: index of the requester that owns the result.
- `rsp_crc`  out  16: CRC result.
- `rsp_err`  out  1: 1 = job timed out (`rsp_crc` = 0).
- `eng_reset_n`  out  1: engine active-low reset.
- `eng_enable`  out  1: engine enable.
- `eng_data`  out  32: engine data word.
- `eng_crc`  in  16: engine result.
- `eng_crc_done`  in  1: engine done flag.

## Operation
- FSM states: IDLE, CLEAR, SETUP, RUN, RESP. All outputs are registered.
- IDLE:
  - `eng_reset_n`=1, `eng_enable`=0, `gnt`=0.
  - If any `req` bit is high, grant the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Latch the owner id and its `req_data` into `eng_data`, then go to CLEAR.
- CLEAR: `eng_reset_n`=0 for exactly 1 cycle, which clears engine state left by any earlier job. Go to SETUP.
- SETUP: `eng_reset_n`=1, `eng_enable`=0, data stable for 1 cycle. Clear the timeout counter. Go to RUN.
- RUN:
  - `eng_enable`=1; the counter increments every cycle.
  - If `eng_crc_done`=1: capture `eng_crc`, set err=0, go to RESP.
  - Otherwise, once the counter shows TIMEOUT cycles spent in RUN: set crc=0, err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins (err=0).
- RESP:
  - `eng_enable`=0, `rsp_valid`=1 for 1 cycle, with `rsp_id`/`rsp_crc`/`rsp_err` valid.
  - `rr_ptr` ← (owner+1) mod NUM_REQ. Go to IDLE.
- `gnt[owner]` is high from CLEAR through RESP inclusive.
- `rsp_id`/`rsp_crc`/`rsp_err` hold their values until the next RESP.
- `eng_data` holds the job word from CLEAR through RESP.
- `req` is sampled only in IDLE. Dropping `req` mid-job does not abort the job; the response is still delivered.
- A requester that does not want another job must deassert `req` on the edge that ends its `rsp_valid` cycle.
- `eng_crc_done` is ignored outside RUN.

## Timing
- Reset values:
  - `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_crc`=0, `rsp_err`=0.
  - `eng_reset_n`=0, `eng_enable`=0, `eng_data`=0.
  - `rr_ptr`=0, state=IDLE.
- Reset asserted mid-job aborts the job with no response, and the engine is held in reset.
- Latency:
  - `req` seen in IDLE at cycle 0 → CLEAR at 1, SETUP at 2, first RUN at 3.
  - Engine done after L RUN cycles gives `rsp_valid` at cycle 3+L.
  - A timeout gives `rsp_valid` at cycle 3+TIMEOUT.
- Back-to-back jobs: minimum 5 cycles per job plus the engine latency; IDLE always lasts at least 1 cycle between jobs.
- `NUM_REQ`=1: `rr_ptr` stays 0 and the single requester is granted every job.

## Test plan
The bench engine model returns `data[31:16]^data[15:0]` and raises done on its 4th enabled cycle.

- Single job: `req[0]` with 0x1234_5678 → `gnt`=0001 on cycles 1–7; `eng_reset_n` low on cycle 1; `eng_enable` high on cycles 3–6; `rsp_valid` at cycle 7 with id 0, crc 0x444C, err 0.
- All four `req` held high, data i = 0x1111_1111·(i+1) → grants in order 0,1,2,3,0, each response id matching its grant, crc = 0x0000 for every job.
- Done suppressed, TIMEOUT=64 → `rsp_valid` at cycle 67 with err 1, crc 0x0000; the next job completes normally with crc 0x444C.
- Done raised in the 64th RUN cycle (TIMEOUT=64) → err 0 and a valid crc.
- `reset` asserted during RUN → `rsp_valid` never pulses, all outputs return to reset values, and a new request after reset is served by requester 0.
- Spurious `eng_crc_done` during IDLE/SETUP → ignored; the job still takes the full 4 RUN cycles.

Source files
------------

// File: rtl/crc_arbiter.sv
// Round-robin arbiter that time-shares one CRC engine among NUM_REQ requesters.
// Each job runs CLEAR -> SETUP -> RUN -> RESP, and a cycle timeout bounds RUN.
module crc_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           rsp_crc,
  output logic                  rsp_err,
  output logic                  eng_reset_n,
  output logic                  eng_enable,
  output logic [31:0]           eng_data,
  input  logic [15:0]           eng_crc,
  input  logic                  eng_crc_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  logic [2:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  cnt;

  logic           found;
  logic [IDW-1:0] sel;
  logic [31:0]    sel_word;
  logic [IDW-1:0] next_ptr;

  // First set request at or after rr_ptr, searching upward with wrap.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_word = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        sel      = IDW'(idx);
        sel_word = req_data[32*idx +: 32];
      end
    end
  end

  assign next_ptr = IDW'((int'(owner) + 1) % NUM_REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      cnt         <= '0;
      gnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_crc     <= '0;
      rsp_err     <= 1'b0;
      eng_reset_n <= 1'b0;
      eng_enable  <= 1'b0;
      eng_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          eng_reset_n <= 1'b1;
          eng_enable  <= 1'b0;
          gnt         <= '0;
          if (found) begin
            owner       <= sel;
            gnt         <= NUM_REQ'(1) << sel;
            eng_data    <= sel_word;
            eng_reset_n <= 1'b0;
            state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          eng_reset_n <= 1'b1;
          state       <= S_SETUP;
        end
        S_SETUP: begin
          cnt        <= '0;
          eng_enable <= 1'b1;
          state      <= S_RUN;
        end
        S_RUN: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (eng_crc_done || cnt == TLAST) begin
            rsp_crc    <= eng_crc_done ? eng_crc : 16'h0000;
            rsp_err    <= !eng_crc_done;
            rsp_id     <= owner;
            rsp_valid  <= 1'b1;
            eng_enable <= 1'b0;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          gnt       <= '0;
          rr_ptr    <= next_ptr;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
